instr_decode: RTL and testbench

- Decode stage of the 5-stage pipeline, directly downstream of the fetch stage.
- Holds the IF/ID pipeline register (instruction, pc+4).
- Contains the 32x32 register file with the write-back port, the main control decoder, the sign extender and load-use hazard detection.
- Drives the ID/EX inputs, and drives a stall back to fetch.

---
 rtl/instr_decode.sv | 131 +++++++++++++
 tb/tb_instr_decode.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode.sv
// Decode stage: IF/ID register, 32-entry register file with write-through,
// main control decoder, sign extender and load-use hazard detection.
module instr_decode #(
    parameter int WIDTH = 32,
    parameter int NREGS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc_next_in,
    input  logic [31:0]      instr_in,
    input  logic             flush,
    input  logic             wb_reg_write,
    input  logic [4:0]       wb_write_reg,
    input  logic [WIDTH-1:0] wb_write_data,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rt,
    output logic             stall,
    output logic [WIDTH-1:0] pc_next_out,
    output logic [WIDTH-1:0] read_data1,
    output logic [WIDTH-1:0] read_data2,
    output logic [WIDTH-1:0] imm_ext,
    output logic [4:0]       rt_out,
    output logic [4:0]       rd_out,
    output logic [4:0]       rs_out,
    output logic             reg_dst,
    output logic             alu_src,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             branch,
    output logic [1:0]       alu_op
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    logic [31:0]      instr_q, instr_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] gpr_q [NREGS];
    logic [WIDTH-1:0] gpr_d [NREGS];

    logic [5:0] opcode;
    logic [4:0] rs, rt;
    logic       wb_en, hit_rs, hit_rt;
    logic [8:0] ctl;

    assign opcode = instr_q[31:26];
    assign rs     = instr_q[25:21];
    assign rt     = instr_q[20:16];

    assign stall = idex_mem_read && (idex_rt != 5'd0)
                && ((idex_rt == rs) || (idex_rt == rt));

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush) begin
            instr_d = '0;
            pc_d    = '0;
        end else if (!stall) begin
            instr_d = instr_in;
            pc_d    = pc_next_in;
        end
    end

    assign wb_en = wb_reg_write && (wb_write_reg != 5'd0);

    always_comb begin
        gpr_d = gpr_q;
        if (wb_en) begin
            gpr_d[wb_write_reg] = wb_write_data;
        end
        gpr_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            instr_q <= '0;
            pc_q    <= '0;
            for (int i = 0; i < NREGS; i++) begin
                gpr_q[i] <= '0;
            end
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            gpr_q   <= gpr_d;
        end
    end

    // Same-cycle write-back is forwarded so WB and ID can overlap.
    assign hit_rs = wb_en && (wb_write_reg == rs);
    assign hit_rt = wb_en && (wb_write_reg == rt);

    assign read_data1 = hit_rs ? wb_write_data : gpr_q[rs];
    assign read_data2 = hit_rt ? wb_write_data : gpr_q[rt];

    assign imm_ext     = {{(WIDTH-16){instr_q[15]}}, instr_q[15:0]};
    assign rs_out      = rs;
    assign rt_out      = rt;
    assign rd_out      = instr_q[15:11];
    assign pc_next_out = pc_q;

    // ctl = {reg_dst, alu_src, mem_to_reg, reg_write,
    //        mem_read, mem_write, branch, alu_op[1:0]}
    always_comb begin
        ctl = 9'b0;
        case (opcode)
            OP_RTYPE: if (instr_q != 32'h0) ctl = 9'b1_0_0_1_0_0_0_10;
            OP_LW:    ctl = 9'b0_1_1_1_1_0_0_00;
            OP_SW:    ctl = 9'b0_1_0_0_0_1_0_00;
            OP_BEQ:   ctl = 9'b0_0_0_0_0_0_1_01;
            default:  ctl = 9'b0;
        endcase
        if (stall) begin
            ctl = 9'b0;
        end
    end

    assign reg_dst    = ctl[8];
    assign alu_src    = ctl[7];
    assign mem_to_reg = ctl[6];
    assign reg_write  = ctl[5];
    assign mem_read   = ctl[4];
    assign mem_write  = ctl[3];
    assign branch     = ctl[2];
    assign alu_op     = ctl[1:0];

endmodule

// File: tb/tb_instr_decode.sv
// Directed bench for the decode stage: reset, register file, decode,
// load-use stall, flush priority and reset during a stall.
module tb_instr_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_next_in;
    logic [31:0] instr_in;
    logic        flush;
    logic        wb_reg_write;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic        idex_mem_read;
    logic [4:0]  idex_rt;
    logic        stall;
    logic [31:0] pc_next_out, read_data1, read_data2, imm_ext;
    logic [4:0]  rt_out, rd_out, rs_out;
    logic        reg_dst, alu_src, mem_to_reg, reg_write;
    logic        mem_read, mem_write, branch;
    logic [1:0]  alu_op;
    logic [8:0]  ctl;

    int total = 0;
    int bad   = 0;

    instr_decode dut (
        .clk(clk), .reset(reset),
        .pc_next_in(pc_next_in), .instr_in(instr_in), .flush(flush),
        .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
        .wb_write_data(wb_write_data),
        .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
        .stall(stall), .pc_next_out(pc_next_out),
        .read_data1(read_data1), .read_data2(read_data2),
        .imm_ext(imm_ext), .rt_out(rt_out), .rd_out(rd_out),
        .rs_out(rs_out), .reg_dst(reg_dst), .alu_src(alu_src),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write),
        .branch(branch), .alu_op(alu_op)
    );

    always #5 clk = ~clk;

    assign ctl = {reg_dst, alu_src, mem_to_reg, reg_write,
                  mem_read, mem_write, branch, alu_op};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        instr_in = 32'h8C220004;
        pc_next_in = 32'h4;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (ctl !== 9'b0) begin
            bad++; $display("FAIL reset_ctl got %b want 0", ctl);
        end
        total++;
        if (stall !== 1'b0) begin
            bad++; $display("FAIL reset_stall got %b want 0", stall);
        end
        total++;
        if ({pc_next_out, imm_ext, read_data1, read_data2} !== 128'h0) begin
            bad++; $display("FAIL reset_data got %h %h %h %h want 0",
                            pc_next_out, imm_ext, read_data1, read_data2);
        end
        total++;
        if ({rs_out, rt_out, rd_out} !== 15'h0) begin
            bad++; $display("FAIL reset_fields got %h want 0",
                            {rs_out, rt_out, rd_out});
        end
        reset = 1'b1;
        for (int i = 1; i < 32; i++) begin
            instr_in = {6'h00, 5'(i), 5'(i), 16'h0000};
            step();
            total++;
            if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin
                bad++; $display("FAIL reset_gpr%0d got %h %h want 0",
                                i, read_data1, read_data2);
            end
        end
    endtask

    task automatic test_lw_decode();
        wb_reg_write = 1'b1;
        wb_write_reg = 5'd1;
        wb_write_data = 32'h10;
        step();
        wb_reg_write = 1'b0;
        instr_in = 32'h8C220004;
        pc_next_in = 32'h104;
        step();
        total++;
        if (read_data1 !== 32'h10) begin
            bad++; $display("FAIL lw_rd1 got %h want 10", read_data1);
        end
        total++;
        if (imm_ext !== 32'h4 || rt_out !== 5'd2 || rs_out !== 5'd1) begin
            bad++; $display("FAIL lw_fields got %h %0d %0d want 4 2 1",
                            imm_ext, rt_out, rs_out);
        end
        total++;
        if (ctl !== 9'b0_1_1_1_1_0_0_00) begin
            bad++; $display("FAIL lw_ctl got %b want 011110000", ctl);
        end
        total++;
        if (pc_next_out !== 32'h104) begin
            bad++; $display("FAIL lw_pc got %h want 104", pc_next_out);
        end
        instr_in = 32'hAC220008;
        step();
        total++;
        if (ctl !== 9'b0_1_0_0_0_1_0_00 || imm_ext !== 32'h8) begin
            bad++; $display("FAIL sw_ctl got %b %h want 010001000 8",
                            ctl, imm_ext);
        end
    endtask

    task automatic test_bypass();
        instr_in = {6'h00, 5'd3, 5'd0, 5'd2, 5'd0, 6'h20};
        step();
        total++;
        if (read_data1 !== 32'h0) begin
            bad++; $display("FAIL byp_pre got %h want 0", read_data1);
        end
        wb_reg_write = 1'b1;
        wb_write_reg = 5'd3;
        wb_write_data = 32'hDEADBEEF;
        #1;
        total++;
        if (read_data1 !== 32'hDEADBEEF) begin
            bad++; $display("FAIL byp_same got %h want deadbeef", read_data1);
        end
        step();
        wb_reg_write = 1'b0;
        #1;
        total++;
        if (read_data1 !== 32'hDEADBEEF) begin
            bad++; $display("FAIL byp_stored got %h want deadbeef", read_data1);
        end
        wb_reg_write = 1'b1;
        wb_write_reg = 5'd0;
        wb_write_data = 32'hFFFFFFFF;
        #1;
        total++;
        if (read_data2 !== 32'h0) begin
            bad++; $display("FAIL r0_bypass got %h want 0", read_data2);
        end
        step();
        wb_reg_write = 1'b0;
        #1;
        total++;
        if (read_data2 !== 32'h0) begin
            bad++; $display("FAIL r0_write got %h want 0", read_data2);
        end
    endtask

    task automatic test_load_use();
        instr_in = {6'h00, 5'd2, 5'd3, 5'd4, 5'd0, 6'h20};
        step();
        idex_mem_read = 1'b1;
        idex_rt = 5'd2;
        instr_in = 32'h10220003;
        #1;
        total++;
        if (stall !== 1'b1) begin
            bad++; $display("FAIL lu_stall got %b want 1", stall);
        end
        total++;
        if (ctl !== 9'b0) begin
            bad++; $display("FAIL lu_bubble got %b want 0", ctl);
        end
        step();
        idex_mem_read = 1'b0;
        #1;
        total++;
        if (rs_out !== 5'd2 || rd_out !== 5'd4) begin
            bad++; $display("FAIL lu_hold got rs=%0d rd=%0d want 2 4",
                            rs_out, rd_out);
        end
        total++;
        if (stall !== 1'b0 || ctl !== 9'b1_0_0_1_0_0_0_10) begin
            bad++; $display("FAIL lu_release got %b %b want 0 100100010",
                            stall, ctl);
        end
        total++;
        if (read_data2 !== 32'hDEADBEEF) begin
            bad++; $display("FAIL lu_rd2 got %h want deadbeef", read_data2);
        end
    endtask

    task automatic test_flush();
        instr_in = 32'h10220003;
        pc_next_in = 32'h200;
        step();
        total++;
        if (ctl !== 9'b0_0_0_0_0_0_1_01 || imm_ext !== 32'h3) begin
            bad++; $display("FAIL beq got %b %h want 000000101 3", ctl, imm_ext);
        end
        flush = 1'b1;
        idex_mem_read = 1'b1;
        idex_rt = 5'd1;
        instr_in = 32'h8C220004;
        #1;
        total++;
        if (stall !== 1'b1) begin
            bad++; $display("FAIL fl_pre_stall got %b want 1", stall);
        end
        step();
        flush = 1'b0;
        #1;
        total++;
        if (stall !== 1'b0 || ctl !== 9'b0) begin
            bad++; $display("FAIL fl_nop got %b %b want 0 0", stall, ctl);
        end
        total++;
        if ({rs_out, rt_out, imm_ext} !== 42'h0) begin
            bad++; $display("FAIL fl_fields got %0d %0d %h want 0",
                            rs_out, rt_out, imm_ext);
        end
        idex_mem_read = 1'b0;
        idex_rt = 5'd0;
    endtask

    task automatic test_neg_imm();
        instr_in = 32'h2002FFFF;
        step();
        total++;
        if (imm_ext !== 32'hFFFFFFFF) begin
            bad++; $display("FAIL neg_imm got %h want ffffffff", imm_ext);
        end
        total++;
        if (ctl !== 9'b0 || rt_out !== 5'd2) begin
            bad++; $display("FAIL unk_op got %b %0d want 0 2", ctl, rt_out);
        end
    endtask

    task automatic test_reset_mid_stall();
        instr_in = 32'h00221820;
        step();
        idex_mem_read = 1'b1;
        idex_rt = 5'd1;
        #1;
        total++;
        if (stall !== 1'b1) begin
            bad++; $display("FAIL rms_pre got %b want 1", stall);
        end
        reset = 1'b0;
        wb_reg_write = 1'b1;
        wb_write_reg = 5'd5;
        wb_write_data = 32'h55;
        step();
        reset = 1'b1;
        wb_reg_write = 1'b0;
        #1;
        total++;
        if (stall !== 1'b0 || ctl !== 9'b0 || rs_out !== 5'd0) begin
            bad++; $display("FAIL rms_clear got %b %b %0d want 0 0 0",
                            stall, ctl, rs_out);
        end
        idex_mem_read = 1'b0;
        instr_in = {6'h00, 5'd5, 5'd1, 16'h0000};
        step();
        total++;
        if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin
            bad++; $display("FAIL rms_gpr got %h %h want 0 0",
                            read_data1, read_data2);
        end
    endtask

    initial begin
        reset = 1'b0;
        pc_next_in = 32'h0;
        instr_in = 32'h0;
        flush = 1'b0;
        wb_reg_write = 1'b0;
        wb_write_reg = 5'd0;
        wb_write_data = 32'h0;
        idex_mem_read = 1'b0;
        idex_rt = 5'd0;
        test_reset();
        test_lw_decode();
        test_bypass();
        test_load_use();
        test_flush();
        test_neg_imm();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
